// File: rtl/wbcon_stream_slave.sv
// wbcon_stream_slave
//   Pipelined Wishbone B4 slave that tunnels each access over a byte link.
//   A request is sent on the Tx stream as one header byte {we, 3'b0, sel[3:0]},
//   then the zero-extended word address, then (writes only) the data word.
//   All multi-byte fields go least-significant byte first. A read completes
//   once WORD_SIZE response bytes have arrived on the Rx stream. Only one
//   access is ever outstanding: o_wb_stall is low only in IDLE.
//
//   Optional build macro: WBCON_STREAM_SLAVE_RX_TIMEOUT_EN
//     When defined, a read gives up after RX_TIMEOUT idle cycles between Rx
//     bytes and acknowledges with the bytes still missing read as 0x00.
//     When undefined, a read waits for its Rx bytes indefinitely and
//     RX_TIMEOUT is not used.

module wbcon_stream_slave #(
    parameter int WB_ADDR_WIDTH = 24,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = (WB_DATA_WIDTH + 7) / 8,
    parameter int RX_TIMEOUT    = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    // Wishbone pipelined slave
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [WB_DATA_WIDTH-1:0] i_wb_data,
    input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
    output logic [WB_DATA_WIDTH-1:0] o_wb_data,
    // Tx byte stream (request)
    output logic                     o_tx_valid,
    output logic [7:0]               o_tx_data,
    input  logic                     i_tx_ready,
    // Rx byte stream (read response)
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_data,
    output logic                     o_rx_ready
);

    localparam int WORD_SIZE  = (WB_DATA_WIDTH + 7) / 8;
    localparam int ADDR_BYTES = (WB_ADDR_WIDTH + 7) / 8;
    localparam int WORD_BITS  = 8 * WORD_SIZE;
    localparam int ADDR_BITS  = 8 * ADDR_BYTES;
    localparam int MAX_BYTES  = (WORD_SIZE > ADDR_BYTES) ? WORD_SIZE : ADDR_BYTES;
    // One spare bit so the counter can step past the last byte index safely.
    localparam int CNT_W      = $clog2(MAX_BYTES) + 1;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_ACK   = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    // Latched request
    logic                     r_we;
    logic [WB_ADDR_WIDTH-1:0] r_addr;
    logic [WB_DATA_WIDTH-1:0] r_data;
    logic [WB_SEL_WIDTH-1:0]  r_sel;

    // Byte index within the current address / data field
    logic [CNT_W-1:0]         r_cnt;

    // Read word assembled from Rx bytes
    logic [WORD_BITS-1:0]     r_rdata;

    logic                     w_accept;
    logic                     w_tx_ack;
    logic                     w_rx_ack;
    logic                     w_addr_last;
    logic                     w_word_last;
    logic                     w_timeout;

    logic [ADDR_BITS-1:0]     w_addr_ext;
    logic [ADDR_BITS-1:0]     w_addr_sh;
    logic [WORD_BITS-1:0]     w_data_ext;
    logic [WORD_BITS-1:0]     w_data_sh;
    logic [3:0]               w_sel4;

    // Handshake events. Accept can only happen in IDLE, where stall is low.
    assign w_accept    = i_wb_cyc && i_wb_stb && (r_state == S_IDLE);
    assign w_tx_ack    = o_tx_valid && i_tx_ready;
    assign w_rx_ack    = i_rx_valid && o_rx_ready;
    assign w_addr_last = (r_cnt == ADDR_LAST);
    assign w_word_last = (r_cnt == WORD_LAST);

    // Byte lanes of the latched request, selected by the byte counter.
    // Address is zero-extended to whole bytes; narrow sel is zero-extended
    // to the 4-bit header field.
    assign w_addr_ext  = ADDR_BITS'(r_addr);
    assign w_data_ext  = WORD_BITS'(r_data);
    assign w_addr_sh   = w_addr_ext >> {r_cnt, 3'b000};
    assign w_data_sh   = w_data_ext >> {r_cnt, 3'b000};
    assign w_sel4      = 4'(r_sel);

    assign o_wb_data   = r_rdata[WB_DATA_WIDTH-1:0];

`ifdef WBCON_STREAM_SLAVE_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_next;

    // Give up on the read at the edge where the idle count would reach
    // RX_TIMEOUT; a byte arriving in that same cycle still wins.
    assign w_to_next = r_to_cnt + 1'b1;
    assign w_timeout = (r_state == S_RDATA) && !w_rx_ack &&
                       (w_to_next == TO_W'(RX_TIMEOUT));

    // Idle-cycle counter: held at zero outside RDATA, restarted by every Rx byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_RDATA) || w_rx_ack) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= w_to_next;
        end
    end
`else
    logic w_unused_cfg;

    // Without the timeout a read only ends on its final Rx byte.
    assign w_timeout    = 1'b0;
    assign w_unused_cfg = (RX_TIMEOUT != 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and all bus/stream outputs, from registered state only
    // (o_wb_ack is additionally qualified by the live cycle signal).
    always_comb begin
        w_next     = r_state;
        o_wb_stall = 1'b1;
        o_wb_ack   = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_rx_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_wb_stall = 1'b0;
                if (w_accept) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {r_we, 3'b000, w_sel4};
                if (w_tx_ack) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = w_addr_sh[7:0];
                if (w_tx_ack && w_addr_last) begin
                    w_next = r_we ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = w_data_sh[7:0];
                if (w_tx_ack && w_word_last) begin
                    w_next = S_ACK;
                end
            end
            S_RDATA: begin
                o_rx_ready = 1'b1;
                if ((w_rx_ack && w_word_last) || w_timeout) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                // A master that dropped cyc mid-access gets no ack, but the
                // link framing has already completed so we simply go idle.
                o_wb_ack = i_wb_cyc;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, byte counter and read-word assembly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we   <= i_wb_we;
                        r_addr <= i_wb_addr;
                        r_data <= i_wb_data;
                        r_sel  <= i_wb_sel;
                        r_cnt  <= '0;
                        // Read data stays visible until the next read starts.
                        if (!i_wb_we) begin
                            r_rdata <= '0;
                        end
                    end
                end
                S_HDR: begin
                    if (w_tx_ack) begin
                        r_cnt <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_tx_ack) begin
                        r_cnt <= w_addr_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (w_tx_ack) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (w_rx_ack) begin
                        for (int i = 0; i < WORD_SIZE; i++) begin
                            if (r_cnt == CNT_W'(i)) begin
                                r_rdata[8*i +: 8] <= i_rx_data;
                            end
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
